// File: rtl/fir_mac_lane.sv
// rtl/fir_mac_lane.sv - one sequential multiply-accumulate lane of the 40-tap FIR

module fir_mac_lane #(
    parameter int DATA_W = 3,
    parameter int COEF_W = 16,
    parameter int TAPS   = 10,
    parameter int OUT_W  = 16
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iEnSample600k,
    input  logic [DATA_W-1:0] iFirIn,
    input  logic              iCoefWr,
    input  logic [3:0]        iCoefAddr,
    input  logic [COEF_W-1:0] iCoefData,
    output logic [OUT_W-1:0]  oMac,
    output logic              oMacValid,
    output logic              oBusy,
    output logic              oOverrun
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);

    localparam logic [4:0] TAPS_L   = 5'(TAPS);
    localparam logic [3:0] LAST_IDX = 4'(TAPS - 1);

    // Saturation thresholds expressed at accumulator width
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic [DATA_W-1:0]        dly  [TAPS];
    logic [COEF_W-1:0]        coef [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [3:0]               idx;

    logic [PROD_W-1:0]        d_ext;
    logic [PROD_W-1:0]        c_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [OUT_W-1:0]         sat_val;
    logic                     coef_wr_ok;
    logic                     shift_en;

    // Tap product for the current index, both operands sign-extended to full product width
    always_comb begin
        d_ext    = {{COEF_W{dly[idx][DATA_W-1]}}, dly[idx]};
        c_ext    = {{DATA_W{coef[idx][COEF_W-1]}}, coef[idx]};
        prod     = $signed(d_ext) * $signed(c_ext);
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

    // Clamp the accumulator into the signed output range
    always_comb begin
        sat_val = acc[OUT_W-1:0];
        if (acc > SAT_MAX) begin
            sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (acc < SAT_MIN) begin
            sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    // Coefficient writes and sample shifts are only honoured while idle
    always_comb begin
        coef_wr_ok = (state == IDLE) && iCoefWr && ({1'b0, iCoefAddr} < TAPS_L);
        shift_en   = (state == IDLE) && iEnSample600k;
    end

    // Coefficient register file; a write coinciding with a strobe lands before the first RUN cycle
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= '0;
            end
        end else if (coef_wr_ok) begin
            coef[iCoefAddr] <= iCoefData;
        end
    end

    // Delay-line segment: newest sample enters at tap 0, oldest falls off the end
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            for (int k = 0; k < TAPS; k++) begin
                dly[k] <= '0;
            end
        end else if (shift_en) begin
            dly[0] <= iFirIn;
            for (int k = 1; k < TAPS; k++) begin
                dly[k] <= dly[k-1];
            end
        end
    end

    // Control FSM with accumulator, result register and status flags
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            oMac      <= '0;
            oMacValid <= 1'b0;
            oBusy     <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            oMacValid <= 1'b0;
            if (iEnSample600k && (state != IDLE)) begin
                oOverrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (iEnSample600k) begin
                        acc   <= '0;
                        idx   <= '0;
                        oBusy <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc + prod_ext;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                DONE: begin
                    oMac      <= sat_val;
                    oMacValid <= 1'b1;
                    oBusy     <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_lane.sv
// tb/tb_fir_mac_lane.sv - self-checking bench for fir_mac_lane

module tb_fir_mac_lane;

    localparam int TAPS = 10;

    logic        iClk12M = 1'b0;
    logic        iRsn;
    logic        iEnSample600k;
    logic [2:0]  iFirIn;
    logic        iCoefWr;
    logic [3:0]  iCoefAddr;
    logic [15:0] iCoefData;
    logic [15:0] oMac;
    logic        oMacValid;
    logic        oBusy;
    logic        oOverrun;

    int checks = 0;
    int errors = 0;

    int m_d[TAPS];
    int m_c[TAPS];

    typedef struct {
        int x;
        int exp;
    } vec_t;

    vec_t imp[11];

    always #5 iClk12M = ~iClk12M;

    fir_mac_lane dut (
        .iClk12M      (iClk12M),
        .iRsn         (iRsn),
        .iEnSample600k(iEnSample600k),
        .iFirIn       (iFirIn),
        .iCoefWr      (iCoefWr),
        .iCoefAddr    (iCoefAddr),
        .iCoefData    (iCoefData),
        .oMac         (oMac),
        .oMacValid    (oMacValid),
        .oBusy        (oBusy),
        .oOverrun     (oOverrun)
    );

    task automatic tick();
        @(posedge iClk12M);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int model_sum();
        int s = 0;
        for (int k = 0; k < TAPS; k++) s += m_d[k] * m_c[k];
        return sat16(s);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < TAPS; k++) begin
            m_d[k] = 0;
            m_c[k] = 0;
        end
    endtask

    task automatic write_coef(input int a, input int v);
        iCoefWr   = 1'b1;
        iCoefAddr = 4'(a);
        iCoefData = 16'(v);
        tick();
        iCoefWr = 1'b0;
        if (a < TAPS) m_c[a] = v;
    endtask

    task automatic model_push(input int x);
        for (int k = TAPS - 1; k > 0; k--) m_d[k] = m_d[k-1];
        m_d[0] = x;
    endtask

    // One sample period of 20 clocks: strobe (optionally with a coefficient write), wait, check
    task automatic run_sample(input int x, input bit wr, input int a, input int v, output int got);
        int cnt;
        bit seen;
        iEnSample600k = 1'b1;
        iFirIn        = 3'(x);
        if (wr) begin
            iCoefWr   = 1'b1;
            iCoefAddr = 4'(a);
            iCoefData = 16'(v);
        end
        tick();
        iEnSample600k = 1'b0;
        iCoefWr       = 1'b0;
        if (wr && a < TAPS) m_c[a] = v;
        model_push(x);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            tick();
            cnt++;
            if (oMacValid) seen = 1'b1;
        end
        chk("valid_seen", int'(seen), 1);
        chk("latency", cnt, TAPS + 1);
        got = int'($signed(oMac));
        chk("mac_vs_model", got, model_sum());
        tick();
        cnt++;
        chk("valid_one_cycle", int'(oMacValid), 0);
        chk("mac_hold", int'($signed(oMac)), got);
        while (cnt < 19) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int cnt;
        bit seen;

        imp[0] = '{1, 1};
        for (int i = 1; i < 10; i++) imp[i] = '{0, i + 1};
        imp[10] = '{0, 0};

        iRsn = 1'b0; iEnSample600k = 1'b0; iFirIn = '0;
        iCoefWr = 1'b0; iCoefAddr = '0; iCoefData = '0;
        model_clear();
        tick(); tick();
        iRsn = 1'b1;
        chk("rst_mac", int'(oMac), 0);
        chk("rst_valid", int'(oMacValid), 0);
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_overrun", int'(oOverrun), 0);

        // impulse response
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        for (int i = 0; i < 11; i++) begin
            run_sample(imp[i].x, 1'b0, 0, 0, got);
            chk("impulse", got, imp[i].exp);
        end

        // positive saturation then flush back to zero
        for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
        for (int i = 0; i < 10; i++) run_sample(3, 1'b0, 0, 0, got);
        chk("pos_sat", got, 32767);
        for (int i = 0; i < 12; i++) run_sample((i < 3) ? (2 - i) : 0, 1'b0, 0, 0, got);
        chk("ramp_zero", got, 0);

        // negative saturation and sign handling
        for (int i = 0; i < 10; i++) run_sample(-4, 1'b0, 0, 0, got);
        chk("neg_sat", got, -32768);
        for (int k = 0; k < TAPS; k++) write_coef(k, -1);
        run_sample(-4, 1'b0, 0, 0, got);
        chk("neg_times_neg", got, 40);

        // overrun and write gating while busy
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        iEnSample600k = 1'b1; iFirIn = 3'(1);
        tick();
        iEnSample600k = 1'b0;
        model_push(1);
        tick(); tick();
        chk("busy_in_run", int'(oBusy), 1);
        iCoefWr = 1'b1; iCoefAddr = 4'd0; iCoefData = 16'd7777;
        tick();
        iCoefWr = 1'b0;
        tick();
        chk("no_overrun_yet", int'(oOverrun), 0);
        iEnSample600k = 1'b1; iFirIn = 3'(3);
        tick();
        iEnSample600k = 1'b0;
        chk("overrun_set", int'(oOverrun), 1);
        cnt = 5; seen = 1'b0;
        while (!seen && cnt < 40) begin
            tick();
            cnt++;
            if (oMacValid) seen = 1'b1;
        end
        chk("ovr_latency", cnt, TAPS + 1);
        chk("ovr_result", int'($signed(oMac)), model_sum());
        chk("busy_cleared", int'(oBusy), 0);
        while (cnt < 19) begin
            tick();
            cnt++;
        end
        run_sample(1, 1'b0, 0, 0, got);
        write_coef(12, 5000);
        run_sample(-1, 1'b0, 0, 0, got);
        chk("overrun_sticky", int'(oOverrun), 1);

        // reset in the middle of RUN
        iEnSample600k = 1'b1; iFirIn = 3'(2);
        tick();
        iEnSample600k = 1'b0;
        tick(); tick(); tick();
        iRsn = 1'b0;
        tick();
        iRsn = 1'b1;
        model_clear();
        chk("abort_mac", int'(oMac), 0);
        chk("abort_valid", int'(oMacValid), 0);
        chk("abort_busy", int'(oBusy), 0);
        chk("abort_overrun", int'(oOverrun), 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (oMacValid) seen = 1'b1;
        end
        chk("no_valid_after_abort", int'(seen), 0);
        run_sample(2, 1'b0, 0, 0, got);
        chk("coefs_cleared", got, 0);

        // random samples and coefficients at nominal rate
        for (int k = 0; k < TAPS; k++) write_coef(k, int'($signed(16'($urandom))));
        for (int i = 0; i < 100; i++) begin
            run_sample(int'($urandom_range(0, 7)) - 4, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 15)), int'($signed(16'($urandom))), got);
        end
        chk("random_no_overrun", int'(oOverrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_mac_lane.md
Name: fir_mac_lane

Overview:
- One of four identical MAC lanes feeding the FIR sum stage.
- Each lane owns TAPS consecutive taps of a 40-tap filter, holding its own delay-line segment and coefficient registers.
- Per 600 kHz sample, the lane runs a sequential multiply-accumulate over its taps in the 12 MHz domain.
- It presents a saturated 16-bit partial sum plus a one-cycle valid strobe. The strobe drives the sum stage's delay enable.

Parameters:
DATA_W, 3, signed input sample width
COEF_W, 16, signed coefficient width
TAPS, 10, taps handled by this lane (max 16)
OUT_W, 16, signed partial-sum output width

Ports:
iClk12M  input  1  system clock, 12 MHz
iRsn  input  1  synchronous active-low reset
iEnSample600k  input  1  one-cycle sample strobe, nominally every 20 clocks
iFirIn  input  DATA_W  signed sample; valid in the cycle iEnSample600k=1
iCoefWr  input  1  coefficient write strobe
iCoefAddr  input  4  coefficient index
iCoefData  input  COEF_W  signed coefficient value
oMac  output  OUT_W  signed saturated partial sum
oMacValid  output  1  one-cycle pulse when oMac updates (to sum-stage delay enable)
oBusy  output  1  high while state is RUN or DONE
oOverrun  output  1  sticky: sample strobe arrived while busy

Behaviour:
- Single clock domain. Everything is sampled on the rising edge of iClk12M.
- Reset: synchronous, active-low, iRsn=0 at an edge.
  - Clears delay line, coefficients, accumulator and tap index to 0.
  - Sets oMac=0, oMacValid=0, oBusy=0, oOverrun=0, state=IDLE.
  - Reset overrides all other inputs the same cycle.
  - Reset mid-RUN aborts the computation: no oMacValid is produced.
- States: IDLE, RUN, DONE.
- IDLE, when iEnSample600k=1:
  - Shift the delay line: d[0] <= iFirIn, d[k] <= d[k-1]. The oldest sample is dropped.
  - Clear the accumulator, set idx=0, go to RUN.
- RUN, each cycle:
  - acc <= acc + d[idx]*c[idx], as a signed product of DATA_W+COEF_W bits.
  - idx increments. After idx=TAPS-1 is accumulated, go to DONE.
  - RUN lasts exactly TAPS cycles.
  - The delay-line shift from the strobe edge is visible to the first RUN cycle.
- DONE, one cycle:
  - oMac <= sat(acc), oMacValid <= 1 (registered, so the pulse appears the next cycle).
  - Return to IDLE.
- Latency: strobe sampled at edge T gives oMac/oMacValid high after edge T+TAPS+1. With TAPS=10 that is 11 cycles, within the 20-cycle sample period.
- oMacValid is high for exactly one cycle. oMac holds its value until the next update.
- Accumulator width: DATA_W+COEF_W+ceil(log2(TAPS)), which is 23 bits for the defaults. It never wraps.
- Saturation:
  - acc > 2^(OUT_W-1)-1 gives 32767.
  - acc < -2^(OUT_W-1) gives -32768.
  - Otherwise the value is truncated to OUT_W bits, which is exact in that range.
- oBusy = 1 in RUN and DONE.
- Strobe while busy: sample ignored (no shift) and oOverrun set to 1. oOverrun stays set until reset.
- Coefficient writes:
  - Accepted only in IDLE, with iCoefWr=1 and iCoefAddr<TAPS. The value is visible from the next cycle.
  - Writes while busy, or with addr>=TAPS, are ignored without error.
- Simultaneous strobe and coefficient write in IDLE: both take effect. The write lands before RUN's first cycle, so the new coefficient is used for this sample.

Test Plan:
- Impulse response: c[k]=k+1 for k=0..9. Strobe every 20 cycles with iFirIn = 1,0,0,… → oMac = 1,2,…,10 on consecutive valids, then 0. Each valid is exactly 11 cycles after its strobe.
- Positive saturation: all c=32767. Ten strobes with iFirIn=3 → final oMac=32767 (raw 983010). A following ramp down to 0 returns oMac to 0.
- Negative saturation and sign: all c=32767, ten strobes of iFirIn=-4 → oMac=-32768. With c=-1 and iFirIn=-4 → oMac=+40.
- Overrun and write gating:
  - A strobe 5 cycles after the previous one → oOverrun=1, delay line unchanged, and the current result completes normally.
  - A coefficient write during RUN is ignored, checked on the next sample.
  - A write to addr 12 is ignored.
- Reset mid-RUN: iRsn=0 at cycle 4 of RUN → no oMacValid, all outputs 0, coefficients cleared. The next strobe after reset gives oMac=0.
- Back-to-back at nominal rate: 100 random samples and random coefficients at a 20-cycle period → oMac matches a reference model (saturated sum) every sample, with oOverrun=0 throughout.
